// File: rtl/dct_pkg.sv
// Shared constants and sample types for the 8-point DCT row/column datapath.
// Used by the row loader, the DCT stages and the multiplier instantiations.
package dct_pkg;

  localparam int N           = 8;
  localparam int PIX_W       = 8;
  localparam int IN_W        = 32;
  localparam int FRAC        = 15;
  localparam int LEVEL_SHIFT = 128;

  typedef logic signed [IN_W-1:0] sample_t;
  typedef sample_t [N-1:0]        row_t;

endpackage

// File: rtl/dct_level_shift.sv
// Combinational pixel-to-sample conversion: removes the DC offset and places
// the centred pixel in signed fixed point with FRAC fractional bits. Exact, no rounding.
module dct_level_shift #(
  parameter int PIX_W = dct_pkg::PIX_W,
  parameter int IN_W  = dct_pkg::IN_W,
  parameter int FRAC  = dct_pkg::FRAC
) (
  input  logic        [PIX_W-1:0] pix,
  output logic signed [IN_W-1:0]  sample
);

  localparam logic signed [PIX_W:0] SHIFT = (PIX_W+1)'(dct_pkg::LEVEL_SHIFT);

  logic signed [PIX_W:0]  centred;
  logic signed [IN_W-1:0] widened;

  // One extra bit holds the full -128..127 range of the centred pixel.
  assign centred = $signed({1'b0, pix}) - SHIFT;
  assign widened = {{(IN_W-PIX_W-1){centred[PIX_W]}}, centred};
  assign sample  = widened <<< FRAC;

endmodule

// File: rtl/dct_row_loader.sv
// Packs a level-shifted pixel stream into N-sample row vectors for the DCT row
// stage. Two ping-pong banks let the writer fill one row while the other waits.
module dct_row_loader #(
  parameter int PIX_W = dct_pkg::PIX_W,
  parameter int IN_W  = dct_pkg::IN_W,
  parameter int FRAC  = dct_pkg::FRAC,
  parameter int N     = dct_pkg::N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIX_W-1:0]       s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N*IN_W-1:0]      m_data,
  output logic [$clog2(N)-1:0]   m_row,
  output logic                   m_last
);

  localparam int CW = $clog2(N);

  logic [IN_W-1:0] bank_data [2][N];
  logic [CW-1:0]   bank_tag  [2];
  logic [1:0]      full;
  logic            wr_bank;
  logic            rd_bank;
  logic [CW-1:0]   col;
  logic [CW-1:0]   rowc;

  logic [IN_W-1:0] sample;
  logic            wr_fire;
  logic            rd_fire;
  logic            row_done;

  dct_level_shift #(
    .PIX_W (PIX_W),
    .IN_W  (IN_W),
    .FRAC  (FRAC)
  ) u_level_shift (
    .pix    (s_data),
    .sample (sample)
  );

  // Ready depends only on the write bank's flag, never on m_ready.
  assign s_ready  = !full[wr_bank] && !rst;
  assign m_valid  = full[rd_bank];
  assign wr_fire  = s_valid && s_ready;
  assign rd_fire  = m_valid && m_ready;
  assign row_done = wr_fire && (col == CW'(N-1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      col     <= '0;
      rowc    <= '0;
      // NOTE: bank storage is cleared too, because the outputs read it
      // directly and must show zero data and row 0 out of reset.
      for (int b = 0; b < 2; b++) begin
        bank_tag[b] <= '0;
        for (int k = 0; k < N; k++) bank_data[b][k] <= '0;
      end
    end else begin
      if (wr_fire) begin
        bank_data[wr_bank][col] <= sample;
        if (row_done) begin
          col               <= '0;
          full[wr_bank]     <= 1'b1;
          bank_tag[wr_bank] <= rowc;
          rowc              <= (rowc == CW'(N-1)) ? '0 : rowc + 1'b1;
          wr_bank           <= ~wr_bank;
        end else begin
          col <= col + 1'b1;
        end
      end
      // A completing write and an accepted read always target opposite banks.
      if (rd_fire) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through it can leave a value held and infer a latch.
  always_comb begin
    m_data = '0;
    for (int k = 0; k < N; k++) m_data[k*IN_W +: IN_W] = bank_data[rd_bank][k];
  end

  assign m_row  = bank_tag[rd_bank];
  assign m_last = (bank_tag[rd_bank] == CW'(N-1));

endmodule

// File: tb/tb_dct_row_loader.sv
// Self-checking bench for dct_row_loader: directed conversion/backpressure/reset
// cases plus random valid/ready traffic checked against a row-level reference model.
module tb_dct_row_loader;

  localparam int N    = 8;
  localparam int IN_W = 32;
  localparam int DW   = N*IN_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [2:0]    m_row;
  logic          m_last;

  dct_row_loader dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_row   (m_row),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } exp_row_t;

  int       n_checks = 0;
  int       n_fail   = 0;
  int       pix_q[$];
  exp_row_t exp_q[$];
  int       row_ctr  = 0;
  int       accepted = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference conversion: centre the pixel, then scale by 2^15.
  function automatic logic [IN_W-1:0] ref_sample(input int p);
    int v;
    v = (p - 128) * 32768;
    return v;
  endfunction

  function automatic void model_accept(input int p);
    exp_row_t r;
    pix_q.push_back(p);
    accepted++;
    if (pix_q.size() == N) begin
      r.data = '0;
      for (int k = 0; k < N; k++) r.data[k*IN_W +: IN_W] = ref_sample(pix_q[k]);
      r.idx = row_ctr;
      exp_q.push_back(r);
      pix_q.delete();
      row_ctr = (row_ctr + 1) % N;
    end
  endfunction

  // One clock: log handshakes seen before the edge, advance, settle.
  task automatic step();
    bit acc;
    bit ro;
    exp_row_t r;
    acc = s_valid && s_ready;
    ro  = m_valid && m_ready;
    if (acc) model_accept(int'(s_data));
    if (ro) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", 1, 0);
      end else begin
        r = exp_q.pop_front();
        check("row_data", m_data, r.data);
        check("row_idx", m_row, r.idx[2:0]);
        check("row_last", m_last, r.idx == N-1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_row", m_row, 0);
    check("rst_m_last", m_last, 0);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 1);
    pix_q.delete();
    exp_q.delete();
    row_ctr  = 0;
    accepted = 0;
  endtask

  int             conv_pix[8] = '{0, 128, 255, 1, 127, 129, 64, 200};
  logic [IN_W-1:0] conv_exp[8] = '{32'hFFC00000, 32'h00000000, 32'h003F8000, 32'hFFC08000,
                                   32'hFFFF8000, 32'h00008000, 32'hFFE00000, 32'h00240000};

  initial begin
    logic [DW-1:0] snap;
    int cyc;

    do_reset();

    // Conversion of known pixels, latency of one cycle after the 8th accept.
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(conv_pix[i]);
      step();
      if (i == N-2) check("conv_no_early_valid", m_valid, 0);
    end
    s_valid = 1'b0;
    check("conv_valid", m_valid, 1);
    check("conv_row", m_row, 0);
    for (int k = 0; k < N; k++) check($sformatf("conv_s%0d", k), m_data[k*IN_W +: IN_W], conv_exp[k]);
    step();
    check("conv_consumed", m_valid, 0);

    // Continuous streaming: 9 rows back to back, ready never drops.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 9*N; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      check("cont_s_ready", s_ready, 1);
      step();
    end
    s_valid = 1'b0;
    step();
    step();
    check("cont_drained", exp_q.size(), 0);

    // Backpressure: two rows absorbed, then stall until row 0 is taken.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      check("bp_s_ready_open", s_ready, 1);
      step();
    end
    s_data = 8'($urandom);
    check("bp_s_ready_closed", s_ready, 0);
    snap = m_data;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", m_data, snap);
      check("bp_hold_ready", s_ready, 0);
      check("bp_hold_row", m_row, 0);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("bp_reopen", s_ready, 1);
    check("bp_next_row", m_row, 1);
    step();
    s_valid = 1'b0;
    check("bp_17th_taken", accepted, 2*N+1);
    m_ready = 1'b1;
    step();
    check("bp_rows_in_order", exp_q.size(), 0);

    // Random valid/ready over 4 blocks.
    do_reset();
    cyc = 0;
    while (accepted < 4*N*N && cyc < 5000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      if (s_valid) s_data = 8'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
    end
    check("rand_all_accepted", accepted, 4*N*N);
    s_valid = 1'b0;
    m_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    check("rand_drained", exp_q.size(), 0);
    step();
    check("rand_no_extra", m_valid, 0);

    // Reset in the middle of a row discards the partial row.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      step();
    end
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = 8'd10;
      step();
    end
    s_valid = 1'b0;
    check("mid_valid", m_valid, 1);
    check("mid_row", m_row, 0);
    for (int k = 0; k < N; k++) check($sformatf("mid_s%0d", k), m_data[k*IN_W +: IN_W], 32'hFFC50000);
    step();
    for (int i = 0; i < 4; i++) begin
      check("mid_single_row", m_valid, 0);
      step();
    end

    // Reset with both banks full leaves nothing behind.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      step();
    end
    s_valid = 1'b0;
    check("full_valid", m_valid, 1);
    check("full_stall", s_ready, 0);
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("full_no_stale", m_valid, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
